// File: rtl/ascon_stream_ctrl.sv
// Host-side sequencer for the Ascon wrapper: splits one input stream into AD/PT
// FIFO pushes, drains ciphertext to an output stream and reports the tag.
module ascon_stream_ctrl #(
  parameter int DATA_AW     = 7,
  parameter int BLOCK_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [DATA_AW-1:0]     cmd_ad_size_i,
  input  logic [DATA_AW-1:0]     cmd_pt_size_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [BLOCK_WIDTH-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BLOCK_WIDTH-1:0] out_data_o,
  output logic                   out_last_o,
  output logic                   tag_valid_o,
  output logic [127:0]           tag_o,
  output logic                   start_o,
  input  logic                   ready_i,
  output logic [DATA_AW-1:0]     ad_size_o,
  output logic [DATA_AW-1:0]     pt_size_o,
  output logic                   ad_push_o,
  output logic [BLOCK_WIDTH-1:0] ad_o,
  input  logic                   ad_full_i,
  output logic                   pt_push_o,
  output logic [BLOCK_WIDTH-1:0] pt_o,
  input  logic                   pt_full_i,
  output logic                   ct_pop_o,
  input  logic [BLOCK_WIDTH-1:0] ct_i,
  input  logic                   ct_empty_i,
  input  logic                   tag_valid_i,
  input  logic [127:0]           tag_i
);

  localparam int CW = DATA_AW + 1;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [DATA_AW-1:0]     ad_size_q, ad_size_d;
  logic [DATA_AW-1:0]     pt_size_q, pt_size_d;
  logic [CW-1:0]          ad_rem_q, ad_rem_d;
  logic [CW-1:0]          pt_rem_q, pt_rem_d;
  logic [CW-1:0]          ct_rem_q, ct_rem_d;
  logic                   tag_seen_q, tag_seen_d;
  logic [127:0]           tag_q, tag_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [BLOCK_WIDTH-1:0] out_data_q, out_data_d;

  logic cmd_fire;
  logic ad_phase;
  logic run_done;

  // Extra count bit keeps 127 bytes + 7 from wrapping before the divide.
  function automatic logic [CW-1:0] num_blocks(input logic [DATA_AW-1:0] size);
    logic [CW-1:0] padded;
    padded = {1'b0, size} + CW'(7);
    return padded >> 3;
  endfunction

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign ad_phase = (ad_rem_q != '0);
  assign run_done = (ad_rem_q == '0) && (pt_rem_q == '0) && (ct_rem_q == '0) &&
                    tag_seen_q && (!out_valid_q || out_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ad_size_q   <= '0;
      pt_size_q   <= '0;
      ad_rem_q    <= '0;
      pt_rem_q    <= '0;
      ct_rem_q    <= '0;
      tag_seen_q  <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ad_size_q   <= ad_size_d;
      pt_size_q   <= pt_size_d;
      ad_rem_q    <= ad_rem_d;
      pt_rem_q    <= pt_rem_d;
      ct_rem_q    <= ct_rem_d;
      tag_seen_q  <= tag_seen_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = START;
      START:   state_d = RUN;
      RUN:     if (run_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    start_o     = 1'b0;
    tag_valid_o = 1'b0;
    in_ready_o  = 1'b0;
    ad_push_o   = 1'b0;
    pt_push_o   = 1'b0;
    ct_pop_o    = 1'b0;
    case (state_q)
      IDLE:  cmd_ready_o = ready_i;
      START: start_o = 1'b1;
      RUN: begin
        in_ready_o = (ad_phase && !ad_full_i) ||
                     (!ad_phase && (pt_rem_q != '0) && !pt_full_i);
        ad_push_o  = in_valid_i && in_ready_o && ad_phase;
        pt_push_o  = in_valid_i && in_ready_o && !ad_phase;
        ct_pop_o   = !ct_empty_i && (ct_rem_q != '0) && (!out_valid_q || out_ready_i);
      end
      DONE:    tag_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ad_size_d   = ad_size_q;
    pt_size_d   = pt_size_q;
    ad_rem_d    = ad_rem_q;
    pt_rem_d    = pt_rem_q;
    ct_rem_d    = ct_rem_q;
    tag_seen_d  = tag_seen_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (state_q == IDLE && cmd_fire) begin
      ad_size_d  = cmd_ad_size_i;
      pt_size_d  = cmd_pt_size_i;
      ad_rem_d   = num_blocks(cmd_ad_size_i);
      pt_rem_d   = num_blocks(cmd_pt_size_i);
      ct_rem_d   = num_blocks(cmd_pt_size_i);
      tag_seen_d = 1'b0;
    end

    if (ad_push_o) ad_rem_d = ad_rem_q - CW'(1);
    if (pt_push_o) pt_rem_d = pt_rem_q - CW'(1);

    // Output register refills on pop, otherwise empties once the sink takes it.
    if (ct_pop_o) begin
      out_data_d  = ct_i;
      out_valid_d = 1'b1;
      out_last_d  = (ct_rem_q == CW'(1));
      ct_rem_d    = ct_rem_q - CW'(1);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == START || state_q == RUN) && tag_valid_i) begin
      tag_d      = tag_i;
      tag_seen_d = 1'b1;
    end
  end

  assign ad_o        = in_data_i;
  assign pt_o        = in_data_i;
  assign ad_size_o   = ad_size_q;
  assign pt_size_o   = pt_size_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// Scoreboard bench for ascon_stream_ctrl with a small behavioural wrapper model
// (CT = PT xor a fixed key, tag released after all blocks are pushed).
module tb_ascon_stream_ctrl;

  localparam logic [63:0] CT_KEY = 64'h5A3C_96F0_0FF0_C3A5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid_i, cmd_ready_o;
  logic [6:0]   cmd_ad_size_i, cmd_pt_size_i;
  logic         in_valid_i, in_ready_o;
  logic [63:0]  in_data_i;
  logic         out_valid_o, out_ready_i, out_last_o;
  logic [63:0]  out_data_o;
  logic         tag_valid_o;
  logic [127:0] tag_o;
  logic         start_o, ready_i;
  logic [6:0]   ad_size_o, pt_size_o;
  logic         ad_push_o, ad_full_i, pt_push_o, pt_full_i;
  logic [63:0]  ad_o, pt_o, ct_i;
  logic         ct_pop_o, ct_empty_i;
  logic         tag_valid_i;
  logic [127:0] tag_i;

  ascon_stream_ctrl #(.DATA_AW(7), .BLOCK_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_ad_size_i(cmd_ad_size_i), .cmd_pt_size_i(cmd_pt_size_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .tag_valid_o(tag_valid_o), .tag_o(tag_o),
    .start_o(start_o), .ready_i(ready_i),
    .ad_size_o(ad_size_o), .pt_size_o(pt_size_o),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i),
    .tag_valid_i(tag_valid_i), .tag_i(tag_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard shared between stimulus and monitor.
  logic [63:0]  exp_ad[$];
  logic [63:0]  exp_pt[$];
  logic [64:0]  exp_out[$];
  logic [127:0] exp_tag;
  int           exp_ad_b, exp_pt_b;
  int           accept_cyc, tag_in_cyc;
  int           start_count, tag_count;
  bit           zero_msg;

  // Wrapper model knobs and state.
  logic [63:0]  ct_fifo[$];
  logic [127:0] model_tag;
  int           need_pushes, pushes_seen, tag_delay, stall_left;
  bit           started, fired, stall_req, stall_done, full_rand;
  int           out_mode;
  bit           m_pop, m_pt_push, m_ad_push, m_start, m_clr;
  logic [63:0]  m_pt_data;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a push, beat or tag.
  bit          prev_hold = 1'b0;
  logic [65:0] prev_val;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (ad_push_o) begin
        check_output("ad_full_push", ad_full_i, 1'b0);
        if (exp_ad.size() == 0) check_output("ad_extra_push", 1'b1, 1'b0);
        else check_output("ad_data", ad_o, exp_ad.pop_front());
      end
      if (pt_push_o) begin
        check_output("pt_after_ad", exp_ad.size(), 0);
        check_output("pt_full_push", pt_full_i, 1'b0);
        if (exp_pt.size() == 0) check_output("pt_extra_push", 1'b1, 1'b0);
        else check_output("pt_data", pt_o, exp_pt.pop_front());
      end
      if (ad_full_i && exp_ad.size() != 0) check_output("ad_stall_ready", in_ready_o, 1'b0);
      if (ct_pop_o) check_output("pop_when_empty", ct_empty_i, 1'b0);
      if (prev_hold) check_output("out_stable", {out_valid_o, out_last_o, out_data_o}, prev_val);
      if (out_valid_o && out_ready_i) begin
        if (exp_out.size() == 0) check_output("out_extra_beat", 1'b1, 1'b0);
        else check_output("out_beat", {out_last_o, out_data_o}, exp_out.pop_front());
      end
      prev_hold = out_valid_o && !out_ready_i;
      prev_val  = {out_valid_o, out_last_o, out_data_o};
      if (tag_valid_i) tag_in_cyc = cyc;
      if (start_o) begin
        start_count++;
        check_output("start_time", cyc, accept_cyc + 1);
        check_output("ad_size", ad_size_o, exp_ad_b);
        check_output("pt_size", pt_size_o, exp_pt_b);
      end
      if (tag_valid_o) begin
        tag_count++;
        check_output("tag_value", tag_o, exp_tag);
        check_output("tag_before_drain", exp_out.size(), 0);
        check_output("tag_pt_left", exp_pt.size() + exp_ad.size(), 0);
        if (zero_msg) check_output("tag_latency", cyc, tag_in_cyc + 2);
      end
    end
  end

  // Wrapper model: CT FIFO, full flags and the tag pulse.
  always begin
    @(negedge clk);
    m_pop     = ct_pop_o;
    m_pt_push = pt_push_o;
    m_pt_data = pt_o;
    m_ad_push = ad_push_o;
    m_start   = start_o;
    m_clr     = rst;
    @(posedge clk);
    #2;
    tag_valid_i = 1'b0;
    tag_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (m_clr) begin
      ct_fifo.delete();
      started    = 1'b0;
      fired      = 1'b0;
      stall_left = 0;
      ad_full_i  = 1'b0;
      pt_full_i  = 1'b0;
    end else begin
      if (m_pop && ct_fifo.size() > 0) void'(ct_fifo.pop_front());
      if (m_pt_push) ct_fifo.push_back(m_pt_data ^ CT_KEY);
      if (m_start) begin
        started     = 1'b1;
        fired       = 1'b0;
        pushes_seen = 0;
        tag_delay   = $urandom_range(0, 3);
      end
      if (m_ad_push || m_pt_push) pushes_seen++;
      if (started && !fired && pushes_seen == need_pushes) begin
        if (tag_delay == 0) begin
          tag_valid_i = 1'b1;
          tag_i       = model_tag;
          fired       = 1'b1;
          started     = 1'b0;
        end else begin
          tag_delay--;
        end
      end
      if (stall_req && m_ad_push && !stall_done) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        ad_full_i = 1'b1;
        stall_left--;
      end else begin
        ad_full_i = full_rand && ($urandom_range(0, 3) == 0);
      end
      pt_full_i = full_rand && ($urandom_range(0, 3) == 0);
    end
    ct_empty_i = (ct_fifo.size() == 0);
    ct_i = (ct_fifo.size() > 0) ? ct_fifo[0] : 64'h0;
  end

  // Output sink: always ready, toggling, or random.
  always begin
    @(posedge clk);
    #1;
    case (out_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = 1'(($urandom_range(0, 1)));
    endcase
  end

  task automatic apply_stimulus(input int ad_b, input int pt_b, input int omode,
                                input bit frand, input bit stall, input int abort_after);
    logic [63:0] words[$];
    logic [63:0] w;
    int nad, npt, idx, hs, n;
    bit acc;
    nad = (ad_b + 7) / 8;
    npt = (pt_b + 7) / 8;
    for (int i = 0; i < nad; i++) begin
      w = {$urandom(), $urandom()};
      words.push_back(w);
      exp_ad.push_back(w);
    end
    for (int i = 0; i < npt; i++) begin
      w = {$urandom(), $urandom()};
      words.push_back(w);
      exp_pt.push_back(w);
      exp_out.push_back({(i == npt - 1), w ^ CT_KEY});
    end
    exp_tag     = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_tag   = exp_tag;
    need_pushes = nad + npt;
    exp_ad_b    = ad_b;
    exp_pt_b    = pt_b;
    zero_msg    = (nad + npt == 0);
    out_mode    = omode;
    full_rand   = frand;
    stall_req   = stall;
    stall_done  = 1'b0;
    start_count = 0;
    tag_count   = 0;

    cmd_valid_i   = 1'b1;
    cmd_ad_size_i = 7'(ad_b);
    cmd_pt_size_i = 7'(pt_b);
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        acc = 1'b1;
        accept_cyc = cyc;
      end
    end
    if (!acc) check_output("cmd_accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid_i   = 1'b0;
    cmd_ad_size_i = 7'($urandom());
    cmd_pt_size_i = 7'($urandom());

    idx = 0;
    hs  = 0;
    n   = 0;
    while (idx < words.size() && n < 3000 && (abort_after < 0 || hs < abort_after)) begin
      in_valid_i = frand ? ($urandom_range(0, 4) != 0) : 1'b1;
      in_data_i  = words[idx];
      @(negedge clk);
      if (in_valid_i && in_ready_o) begin
        idx++;
        hs++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    if (abort_after >= 0) return;
    if (idx < words.size()) check_output("feed_timeout", idx, words.size());

    n = 0;
    while (tag_count == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (tag_count == 0) check_output("tag_timeout", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_output("tag_pulse_count", tag_count, 1);
    check_output("start_pulse_count", start_count, 1);
    check_output("beats_left", exp_out.size(), 0);
  endtask

  task automatic reset_mid_run();
    apply_stimulus(40, 64, 2, 1'b0, 1'b0, 3);
    rst         = 1'b1;
    cmd_valid_i = 1'b1;
    ready_i     = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cmd_valid_i = 1'b0;
    exp_ad.delete();
    exp_pt.delete();
    exp_out.delete();
    @(negedge clk);
    check_output("rst_strobes",
                 {start_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o,
                  ad_push_o, pt_push_o, ct_pop_o, cmd_ready_o}, 9'b0);
    check_output("rst_out_data", out_data_o, 64'h0);
    check_output("rst_tag", tag_o, 128'h0);
    check_output("rst_sizes", {ad_size_o, pt_size_o}, 14'h0);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(negedge clk);
    check_output("cmd_ready_after_rst", cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid_i   = 1'b0;
    cmd_ad_size_i = '0;
    cmd_pt_size_i = '0;
    in_valid_i    = 1'b0;
    in_data_i     = '0;
    out_ready_i   = 1'b1;
    out_mode      = 0;
    ready_i       = 1'b1;
    ad_full_i     = 1'b0;
    pt_full_i     = 1'b0;
    ct_empty_i    = 1'b1;
    ct_i          = '0;
    tag_valid_i   = 1'b0;
    tag_i         = '0;
    need_pushes   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_strobes",
                 {start_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o,
                  ad_push_o, pt_push_o, ct_pop_o}, 8'b0);
    check_output("reset_data", {out_data_o, ad_size_o, pt_size_o}, 78'h0);
    check_output("reset_tag", tag_o, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    apply_stimulus(16, 24, 0, 1'b0, 1'b0, -1);
    apply_stimulus(0, 0, 0, 1'b0, 1'b0, -1);
    apply_stimulus(1, 127, 0, 1'b0, 1'b0, -1);
    apply_stimulus(40, 16, 0, 1'b0, 1'b1, -1);
    apply_stimulus(24, 64, 1, 1'b0, 1'b0, -1);
    apply_stimulus(0, 9, 1, 1'b0, 1'b0, -1);
    apply_stimulus(13, 0, 2, 1'b1, 1'b0, -1);
    reset_mid_run();
    apply_stimulus(16, 24, 2, 1'b1, 1'b0, -1);
    for (int m = 0; m < 20; m++) begin
      int a, p;
      a = $urandom_range(0, 127);
      p = $urandom_range(0, 127);
      apply_stimulus(a, p, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     (a > 8) && ($urandom_range(0, 1) == 1), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
